digit_entry_octal_hex: RTL and testbench

- Input-side counterpart of the octal/hex 7-segment display path.
- Assembles an 8-bit binary value from digits keyed one at a time, most significant digit first, in octal (sel=0) or hexadecimal (sel=1).
- Commits the value to BIN on an enter strobe. BIN feeds the octal/hex display mux directly.
- Also exposes the partial entry so the displays can preview digits while they are being keyed.

---
 rtl/digit_entry_octal_hex.sv | 94 +++++++++
 tb/tb_digit_entry_octal_hex.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_octal_hex.sv
// Keyed octal/hex digit entry: builds an 8-bit value MSD-first, commits to BIN.
// Ports: clk, reset, sel, digit, digit_stb, enter, clear -> BIN, bin_valid, ENTRY_VAL, cnt, err.
module digit_entry_octal_hex (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [3:0] digit,
  input  logic       digit_stb,
  input  logic       enter,
  input  logic       clear,
  output logic [7:0] BIN,
  output logic       bin_valid,
  output logic [7:0] ENTRY_VAL,
  output logic [1:0] cnt,
  output logic       err
);

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL
  } state_t;

  state_t     state, state_n;
  logic       sel_q;
  logic [7:0] bin_n, val_n, shifted;
  logic [1:0] cnt_n, cnt_inc, limit;
  logic       valid_n, err_n;
  logic       base_chg, digit_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      sel_q     <= sel;
      BIN       <= 8'h00;
      bin_valid <= 1'b0;
      ENTRY_VAL <= 8'h00;
      cnt       <= 2'd0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      sel_q     <= sel;
      BIN       <= bin_n;
      bin_valid <= valid_n;
      ENTRY_VAL <= val_n;
      cnt       <= cnt_n;
      err       <= err_n;
    end
  end

  always_comb begin
    base_chg = (sel != sel_q);
    limit    = sel_q ? 2'd2 : 2'd3;
    cnt_inc  = cnt + 2'd1;
    shifted  = sel_q ? {ENTRY_VAL[3:0], digit}
                     : {ENTRY_VAL[4:0], digit[2:0]};
    // A third octal digit only fits if the first two are <= 0o37.
    digit_ok = (state != FULL)
            && (sel_q || (digit <= 4'd7))
            && (sel_q || (cnt != 2'd2) || (ENTRY_VAL <= 8'o037));

    state_n = state;
    bin_n   = BIN;
    val_n   = ENTRY_VAL;
    cnt_n   = cnt;
    valid_n = 1'b0;
    err_n   = 1'b0;

    if (clear || base_chg) begin
      val_n   = 8'h00;
      cnt_n   = 2'd0;
      state_n = EMPTY;
    end else if (enter) begin
      if (cnt != 2'd0) begin
        bin_n   = ENTRY_VAL;
        valid_n = 1'b1;
        val_n   = 8'h00;
        cnt_n   = 2'd0;
        state_n = EMPTY;
      end else begin
        err_n = 1'b1;
      end
    end else if (digit_stb) begin
      if (digit_ok) begin
        val_n   = shifted;
        cnt_n   = cnt_inc;
        state_n = (cnt_inc == limit) ? FULL : ENTRY;
      end else begin
        err_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_entry_octal_hex.sv
// Scoreboard bench for digit_entry_octal_hex.
// Directed cycles push expected outputs; they are popped after each edge.
module tb_digit_entry_octal_hex;

  logic       clk;
  logic       reset;
  logic       sel;
  logic [3:0] digit;
  logic       digit_stb;
  logic       enter;
  logic       clear;
  logic [7:0] BIN;
  logic       bin_valid;
  logic [7:0] ENTRY_VAL;
  logic [1:0] cnt;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] val;
    logic [1:0] cnt;
    logic       err;
    logic       vld;
    logic [7:0] bin;
  } exp_t;

  exp_t sbq[$];

  digit_entry_octal_hex dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .digit     (digit),
    .digit_stb (digit_stb),
    .enter     (enter),
    .clear     (clear),
    .BIN       (BIN),
    .bin_valid (bin_valid),
    .ENTRY_VAL (ENTRY_VAL),
    .cnt       (cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic s, input logic [3:0] d,
                      input logic ds, input logic en,
                      input logic cl,
                      input logic [7:0] ev, input logic [1:0] ec,
                      input logic ee, input logic evl,
                      input logic [7:0] eb);
    exp_t e;
    @(negedge clk);
    sel = s;
    digit = d;
    digit_stb = ds;
    enter = en;
    clear = cl;
    e.val = ev;
    e.cnt = ec;
    e.err = ee;
    e.vld = evl;
    e.bin = eb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    digit_stb = 1'b0;
    enter = 1'b0;
    clear = 1'b0;
    if (sbq.size() == 0) begin
      chk({tag, ".sb"}, 8'd0, 8'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".val"}, ENTRY_VAL, e.val);
      chk({tag, ".cnt"}, {6'd0, cnt}, {6'd0, e.cnt});
      chk({tag, ".err"}, {7'd0, err}, {7'd0, e.err});
      chk({tag, ".vld"}, {7'd0, bin_valid}, {7'd0, e.vld});
      chk({tag, ".bin"}, BIN, e.bin);
      chk({tag, ".excl"}, {7'd0, err & bin_valid}, 8'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".val"}, ENTRY_VAL, 8'h00);
    chk({tag, ".cnt"}, {6'd0, cnt}, 8'd0);
    chk({tag, ".err"}, {7'd0, err}, 8'd0);
    chk({tag, ".vld"}, {7'd0, bin_valid}, 8'd0);
    chk({tag, ".bin"}, BIN, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    digit = 4'd0;
    digit_stb = 1'b0;
    enter = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // octal 3,7,7 then enter
    step("o3",   0, 3, 1, 0, 0, 8'h03, 1, 0, 0, 8'h00);
    step("o37",  0, 7, 1, 0, 0, 8'h1F, 2, 0, 0, 8'h00);
    step("o377", 0, 7, 1, 0, 0, 8'hFF, 3, 0, 0, 8'h00);
    step("oent", 0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 8'hFF);
    step("oidl", 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'hFF);

    // hex A,5, extra F rejected, enter
    step("hchg", 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'hFF);
    step("hA",   1, 4'hA, 1, 0, 0, 8'h0A, 1, 0, 0, 8'hFF);
    step("hA5",  1, 4'h5, 1, 0, 0, 8'hA5, 2, 0, 0, 8'hFF);
    step("hfull",1, 4'hF, 1, 0, 0, 8'hA5, 2, 1, 0, 8'hFF);
    step("hent", 1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 8'hA5);

    // octal overflow and illegal digit
    step("ochg", 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'hA5);
    step("o4",   0, 4, 1, 0, 0, 8'h04, 1, 0, 0, 8'hA5);
    step("o40",  0, 0, 1, 0, 0, 8'h20, 2, 0, 0, 8'hA5);
    step("oovf", 0, 0, 1, 0, 0, 8'h20, 2, 1, 0, 8'hA5);
    step("o8",   0, 8, 1, 0, 0, 8'h20, 2, 1, 0, 8'hA5);
    step("oclr", 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 8'hA5);

    // clear beats enter
    step("c1",   0, 1, 1, 0, 0, 8'h01, 1, 0, 0, 8'hA5);
    step("c12",  0, 2, 1, 0, 0, 8'h0A, 2, 0, 0, 8'hA5);
    step("clen", 0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 8'hA5);

    // base change beats digit and enter
    step("bchg", 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'hA5);
    step("bC",   1, 4'hC, 1, 0, 0, 8'h0C, 1, 0, 0, 8'hA5);
    step("bdig", 0, 3, 1, 0, 0, 8'h00, 0, 0, 0, 8'hA5);
    step("e0",   0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 8'hA5);
    step("b5",   0, 5, 1, 0, 0, 8'h05, 1, 0, 0, 8'hA5);
    step("bent", 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 8'hA5);

    // clear beats digit, held strobe counts twice
    step("x7",   1, 7, 1, 0, 0, 8'h07, 1, 0, 0, 8'hA5);
    step("xclr", 1, 9, 1, 0, 1, 8'h00, 0, 0, 0, 8'hA5);
    step("hold1",1, 5, 1, 0, 0, 8'h05, 1, 0, 0, 8'hA5);
    step("hold2",1, 5, 1, 0, 0, 8'h55, 2, 0, 0, 8'hA5);
    step("hclr", 1, 0, 0, 0, 1, 8'h00, 0, 0, 0, 8'hA5);
    step("h5",   1, 5, 1, 0, 0, 8'h05, 1, 0, 0, 8'hA5);
    step("h5A",  1, 4'hA, 1, 0, 0, 8'h5A, 2, 0, 0, 8'hA5);
    step("h5Ae", 1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 8'h5A);
    step("h1",   1, 1, 1, 0, 0, 8'h01, 1, 0, 0, 8'h5A);

    // asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge clk);
    reset = 1'b0;

    step("r1",   1, 1, 1, 0, 0, 8'h01, 1, 0, 0, 8'h00);
    step("r12",  1, 2, 1, 0, 0, 8'h12, 2, 0, 0, 8'h00);
    step("rent", 1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 8'h12);
    step("ridl", 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h12);

    if (sbq.size() != 0)
      chk("sb_left", 8'(sbq.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
